// File: rtl/sine_voice_scheduler_pkg.sv
// ============================================================================
//  Module   : sine_voice_scheduler_pkg
//  Purpose  : Shared widths, phase field positions and FSM encoding for the
//             sine voice scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sine_voice_scheduler_pkg;

    localparam int PHASE_W    = 22;
    localparam int ROM_ADDR_W = 10;
    localparam int STEP_W     = 20;
    localparam int SAMPLE_W   = 16;

    // Phase layout: [21:20] quadrant, [19:10] table index, [9:0] fraction.
    localparam int QUAD_MSB = 21;
    localparam int QUAD_LSB = 20;
    localparam int IDX_MSB  = 19;
    localparam int IDX_LSB  = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/dffr.sv
// ============================================================================
//  Module   : dffr
//  Purpose  : Generic register with synchronous active-high reset and enable.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dffr #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sine_voice_scheduler_fold.sv
// ============================================================================
//  Module   : sine_voice_scheduler_fold
//  Purpose  : Quarter-wave fold: mirrors the table address in odd quadrants
//             and negates the magnitude in the lower half-period.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sine_voice_scheduler_fold
    import sine_voice_scheduler_pkg::*;
(
    input  logic [1:0]                 addr_quad_i,
    input  logic [ROM_ADDR_W-1:0]      index_i,
    input  logic [1:0]                 data_quad_i,
    input  logic [SAMPLE_W-1:0]        rom_data_i,
    output logic [ROM_ADDR_W-1:0]      rom_addr_o,
    output logic signed [SAMPLE_W-1:0] folded_o
);

    // Address uses the live phase quadrant; sign uses the quadrant captured
    // alongside the ROM request, since data returns one cycle later.
    assign rom_addr_o = addr_quad_i[0] ? ~index_i : index_i;
    assign folded_o   = data_quad_i[1] ? $signed(~rom_data_i + 16'd1)
                                       : $signed(rom_data_i);

endmodule

`default_nettype wire

// File: rtl/sine_voice_scheduler.sv
// ============================================================================
//  Module   : sine_voice_scheduler
//  Purpose  : Time-multiplexes one quarter-wave sine ROM across NUM_VOICES
//             phase accumulators and emits one mixed, saturated sample.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sine_voice_scheduler
    import sine_voice_scheduler_pkg::*;
#(
    parameter int NUM_VOICES = 3,
    parameter int MIX_SHIFT  = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [STEP_W*NUM_VOICES-1:0] step_size,
    input  logic [NUM_VOICES-1:0]        voice_en,
    input  logic                         generate_next,
    output logic [ROM_ADDR_W-1:0]        rom_addr,
    input  logic [SAMPLE_W-1:0]          rom_data,
    output logic [SAMPLE_W-1:0]          sample,
    output logic                         sample_ready,
    output logic                         busy,
    output logic                         overrun
);

    localparam int ACC_W  = SAMPLE_W + 3;
    localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [VIDX_W-1:0]       C_LAST_VOICE = VIDX_W'(NUM_VOICES - 1);
    localparam logic signed [ACC_W-1:0] C_SAT_MAX    = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] C_SAT_MIN    = -ACC_W'(32768);

    state_e                    state_q, state_d;
    logic [VIDX_W-1:0]         voice_q, voice_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [ACC_W-1:0]   acc_shifted;
    logic [1:0]                quad_q, quad_d;
    logic [SAMPLE_W-1:0]       sample_q, sample_d;
    logic                      ready_q, ready_d;
    logic                      overrun_q, overrun_d;

    logic [PHASE_W-1:0]        phase_q [NUM_VOICES];
    logic [PHASE_W-1:0]        phase_d [NUM_VOICES];
    logic [NUM_VOICES-1:0]     phase_en;
    logic [PHASE_W-1:0]        cur_phase;
    logic [ROM_ADDR_W-1:0]     fold_addr;
    logic signed [SAMPLE_W-1:0] folded;

    genvar v;
    generate
        for (v = 0; v < NUM_VOICES; v++) begin : g_voice
            // A disabled voice is cleared so it restarts at phase 0 when re-enabled.
            assign phase_en[v] = (state_q == ST_CAPTURE) && (voice_q == VIDX_W'(v));
            assign phase_d[v]  = voice_en[v]
                               ? phase_q[v] + {2'b00, step_size[STEP_W*v +: STEP_W]}
                               : '0;

            dffr #(.WIDTH(PHASE_W)) u_phase (
                .clk (clk),
                .rst (reset),
                .en  (phase_en[v]),
                .d   (phase_d[v]),
                .q   (phase_q[v])
            );
        end
    endgenerate

    assign cur_phase = phase_q[voice_q];

    sine_voice_scheduler_fold u_fold (
        .addr_quad_i (cur_phase[QUAD_MSB:QUAD_LSB]),
        .index_i     (cur_phase[IDX_MSB:IDX_LSB]),
        .data_quad_i (quad_q),
        .rom_data_i  (rom_data),
        .rom_addr_o  (fold_addr),
        .folded_o    (folded)
    );

    assign acc_sum     = voice_en[voice_q]
                       ? acc_q + {{(ACC_W-SAMPLE_W){folded[SAMPLE_W-1]}}, folded}
                       : acc_q;
    assign acc_shifted = acc_sum >>> MIX_SHIFT;

    always_comb begin
        state_d   = state_q;
        voice_d   = voice_q;
        acc_d     = acc_q;
        quad_d    = quad_q;
        sample_d  = sample_q;
        ready_d   = 1'b0;
        overrun_d = overrun_q | (generate_next && (state_q != ST_IDLE));

        case (state_q)
            ST_IDLE: begin
                if (generate_next) begin
                    state_d = ST_FETCH;
                    voice_d = '0;
                    acc_d   = '0;
                end
            end
            ST_FETCH: begin
                quad_d  = cur_phase[QUAD_MSB:QUAD_LSB];
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                acc_d = acc_sum;
                if (voice_q == C_LAST_VOICE) begin
                    // Sample and pulse are registered so both are visible in DONE.
                    state_d = ST_DONE;
                    ready_d = 1'b1;
                    if (acc_shifted > C_SAT_MAX) begin
                        sample_d = 16'h7FFF;
                    end else if (acc_shifted < C_SAT_MIN) begin
                        sample_d = 16'h8000;
                    end else begin
                        sample_d = acc_shifted[SAMPLE_W-1:0];
                    end
                end else begin
                    voice_d = voice_q + VIDX_W'(1);
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            voice_q   <= '0;
            acc_q     <= '0;
            quad_q    <= '0;
            sample_q  <= '0;
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            voice_q   <= voice_d;
            acc_q     <= acc_d;
            quad_q    <= quad_d;
            sample_q  <= sample_d;
            ready_q   <= ready_d;
            overrun_q <= overrun_d;
        end
    end

    assign rom_addr     = (state_q == ST_FETCH) ? fold_addr : '0;
    assign sample       = sample_q;
    assign sample_ready = ready_q;
    assign busy         = (state_q != ST_IDLE);
    assign overrun      = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_sine_voice_scheduler.sv
// ============================================================================
//  Module   : tb_sine_voice_scheduler
//  Purpose  : Directed, table-driven bench for sine_voice_scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sine_voice_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [59:0] step_size;
    logic [2:0]  voice_en;
    logic        generate_next;
    logic [9:0]  rom_addr, rom_addr_sat;
    logic [15:0] rom_data, rom_data_sat;
    logic [15:0] sample, sample_sat;
    logic        sample_ready, sample_ready_sat;
    logic        busy, busy_sat;
    logic        overrun, overrun_sat;
    logic        rom_force;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sine_voice_scheduler #(.NUM_VOICES(3), .MIX_SHIFT(2)) dut (
        .clk(clk), .reset(reset), .step_size(step_size), .voice_en(voice_en),
        .generate_next(generate_next), .rom_addr(rom_addr), .rom_data(rom_data),
        .sample(sample), .sample_ready(sample_ready), .busy(busy), .overrun(overrun)
    );

    sine_voice_scheduler #(.NUM_VOICES(3), .MIX_SHIFT(0)) dut_sat (
        .clk(clk), .reset(reset), .step_size(step_size), .voice_en(voice_en),
        .generate_next(generate_next), .rom_addr(rom_addr_sat), .rom_data(rom_data_sat),
        .sample(sample_sat), .sample_ready(sample_ready_sat), .busy(busy_sat),
        .overrun(overrun_sat)
    );

    // ROM stand-in: value = addr*32 + 7 (stays within 0..0x7FFF), or forced full scale.
    always @(posedge clk) begin
        rom_data     <= rom_force ? 16'h7FFF : {1'b0, rom_addr, 5'd0} + 16'd7;
        rom_data_sat <= rom_force ? 16'h7FFF : {1'b0, rom_addr_sat, 5'd0} + 16'd7;
    end

    typedef struct {
        logic [9:0] addr;
        int         samp;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Issues one request from IDLE; returns cycle of sample_ready and voice fetch addresses.
    task automatic do_req(output int lat, output logic [9:0] a0, output logic [9:0] a1,
                          output logic [9:0] a2, output int s, output int s_sat);
        int n;
        generate_next = 1'b1;
        tick();
        generate_next = 1'b0;
        n  = 1;
        a0 = rom_addr;
        a1 = '0;
        a2 = '0;
        while (!sample_ready && n < 20) begin
            tick();
            n++;
            if (n == 3) a1 = rom_addr;
            if (n == 5) a2 = rom_addr;
        end
        lat   = n;
        s     = int'($signed(sample));
        s_sat = int'($signed(sample_sat));
        tick();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         lat, s, s_sat, cnt, rdy_cyc;
        logic [9:0] a0, a1, a2;

        tbl[0] = '{10'd0,    1};
        tbl[1] = '{10'd512,  4097};
        tbl[2] = '{10'd1023, 8185};
        tbl[3] = '{10'd511,  4089};
        tbl[4] = '{10'd0,    -2};
        tbl[5] = '{10'd512,  -4098};
        tbl[6] = '{10'd1023, -8186};
        tbl[7] = '{10'd511,  -4090};

        reset         = 1'b1;
        step_size     = '0;
        voice_en      = '0;
        generate_next = 1'b0;
        rom_force     = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) tick();
        chk("idle_sample", int'(sample), 0);
        chk("idle_ready", int'(sample_ready), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_rom_addr", int'(rom_addr), 0);
        chk("idle_overrun", int'(overrun), 0);

        // Single voice sweep through all four quadrants
        voice_en  = 3'b001;
        step_size = {20'h0, 20'h0, 20'h80000};
        for (int i = 0; i < 8; i++) begin
            do_req(lat, a0, a1, a2, s, s_sat);
            chk($sformatf("v0_addr[%0d]", i), int'(a0), int'(tbl[i].addr));
            chk($sformatf("v0_sample[%0d]", i), s, tbl[i].samp);
            chk($sformatf("v0_latency[%0d]", i), lat, 7);
            chk($sformatf("v0_ready_low[%0d]", i), int'(sample_ready), 0);
        end

        // Three full-scale voices, quadrant 0 then quadrant 2, with and without shift
        do_reset();
        rom_force = 1'b1;
        voice_en  = 3'b111;
        step_size = {20'h00400, 20'h00400, 20'h00400};
        do_req(lat, a0, a1, a2, s, s_sat);
        chk("q0_sum", s, 24575);
        chk("q0_sat_pos", s_sat, 32767);
        for (int i = 1; i < 2048; i++) do_req(lat, a0, a1, a2, s, s_sat);
        do_req(lat, a0, a1, a2, s, s_sat);
        chk("q2_sum", s, -24576);
        chk("q2_sat_neg", s_sat, -32768);
        rom_force = 1'b0;

        // Overrun: second request in cycle 3 is dropped and flagged
        do_reset();
        voice_en      = 3'b001;
        step_size     = {20'h0, 20'h0, 20'h80000};
        cnt           = 0;
        rdy_cyc       = 0;
        generate_next = 1'b1;
        tick();
        generate_next = 1'b0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            if (cyc == 3) begin
                chk("overrun_before", int'(overrun), 0);
                generate_next = 1'b1;
            end
            if (cyc == 4) begin
                generate_next = 1'b0;
                chk("overrun_set", int'(overrun), 1);
            end
            if (sample_ready) begin
                cnt++;
                rdy_cyc = cyc;
            end
            tick();
        end
        chk("overrun_ready_count", cnt, 1);
        chk("overrun_ready_cycle", rdy_cyc, 7);
        chk("overrun_sticky", int'(overrun), 1);
        do_reset();
        chk("overrun_cleared", int'(overrun), 0);

        // Voice disable / re-enable restarts phase at 0
        voice_en  = 3'b010;
        step_size = {20'h0, 20'h80000, 20'h0};
        for (int i = 0; i < 5; i++) begin
            do_req(lat, a0, a1, a2, s, s_sat);
            chk($sformatf("v1_addr[%0d]", i), int'(a1), int'(tbl[i].addr));
            chk($sformatf("v1_sample[%0d]", i), s, tbl[i].samp);
        end
        voice_en = 3'b000;
        do_req(lat, a0, a1, a2, s, s_sat);
        chk("all_off_addr", int'(a1), 512);
        chk("all_off_sample", s, 0);
        chk("all_off_latency", lat, 7);
        voice_en = 3'b010;
        do_req(lat, a0, a1, a2, s, s_sat);
        chk("reenable_addr", int'(a1), 0);
        chk("reenable_sample", s, 1);

        // Reset in cycle 4 of a sequence aborts it
        voice_en  = 3'b001;
        step_size = {20'h0, 20'h0, 20'h80000};
        do_req(lat, a0, a1, a2, s, s_sat);
        chk("pre_abort_sample", s, 1);
        cnt           = 0;
        generate_next = 1'b1;
        tick();
        generate_next = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (cyc == 4) reset = 1'b1;
            if (cyc == 5) begin
                reset = 1'b0;
                chk("abort_busy", int'(busy), 0);
                chk("abort_rom_addr", int'(rom_addr), 0);
                chk("abort_sample", int'(sample), 0);
            end
            if (sample_ready) cnt++;
            tick();
        end
        chk("abort_no_ready", cnt, 0);
        do_req(lat, a0, a1, a2, s, s_sat);
        chk("post_abort_addr", int'(a0), 0);
        chk("post_abort_sample", s, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
